ddr2_burst_ctrl: RTL and testbench

- Bridges the host pipe FIFOs and MCB port 0 of the Spartan-6 DDR2 controller in the RAMTester design.
- In write mode it drains the pipe-in FIFO in fixed-length bursts into the MCB write path and issues write commands.
- In read mode it issues read commands and moves returned data into the pipe-out FIFO.
- It holds independent write and read byte-address counters, each of which wraps at a configurable limit.

---
 rtl/ddr2_burst_ctrl_if.sv | 39 +++
 rtl/ddr2_burst_ctrl.sv | 128 ++++++++++++
 tb/tb_ddr2_burst_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr2_burst_ctrl_if.sv
// Pipe-FIFO and MCB port-0 signal bundle for ddr2_burst_ctrl.
// master = burst controller side, slave = FIFO / MCB side.
interface ddr2_burst_ctrl_if;
  logic        ib_re;
  logic [31:0] ib_data;
  logic        ib_valid;
  logic [9:0]  ib_count;
  logic        ob_we;
  logic [31:0] ob_data;
  logic [9:0]  ob_count;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_cmd_full;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic [3:0]  p0_wr_mask;
  logic        p0_wr_full;
  logic        p0_rd_en;
  logic [31:0] p0_rd_data;
  logic        p0_rd_empty;

  modport master (
    output ib_re, ob_we, ob_data,
    output p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
    output p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en,
    input  ib_data, ib_valid, ib_count, ob_count,
    input  p0_cmd_full, p0_wr_full, p0_rd_data, p0_rd_empty
  );

  modport slave (
    input  ib_re, ob_we, ob_data,
    input  p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr,
    input  p0_wr_en, p0_wr_data, p0_wr_mask, p0_rd_en,
    output ib_data, ib_valid, ib_count, ob_count,
    output p0_cmd_full, p0_wr_full, p0_rd_data, p0_rd_empty
  );
endinterface

// File: rtl/ddr2_burst_ctrl.sv
// Burst mover between host pipe FIFOs and MCB port 0 (write fill/cmd, read cmd/drain).
// Optional burst statistics counters are built when BURST_CTRL_STATS_EN is defined.
module ddr2_burst_ctrl #(
  parameter int          BURST_LEN = 32,
  parameter int          OB_DEPTH  = 1024,
  parameter logic [29:0] ADDR_WRAP = 30'h0400_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               calib_done,
  input  logic               writes_en,
  input  logic               reads_en,
  ddr2_burst_ctrl_if.master  bus,
  output logic [15:0]        wr_burst_count,
  output logic [15:0]        rd_burst_count
);

  typedef enum logic [2:0] {IDLE, WR_FILL, WR_CMD, RD_CMD, RD_DRAIN} state_t;

  localparam logic [29:0] STEP  = 30'(4 * BURST_LEN);
  localparam logic [6:0]  BL    = 7'(BURST_LEN);
  localparam logic [6:0]  BL_M1 = 7'(BURST_LEN - 1);

  state_t      state;
  logic [6:0]  req_cnt;
  logic [6:0]  push_cnt;
  logic [6:0]  pop_cnt;
  logic [29:0] wr_addr;
  logic [29:0] rd_addr;
  logic        wr_room;
  logic        rd_room;

  function automatic logic [29:0] next_addr(input logic [29:0] a);
    logic [29:0] n;
    n = a + STEP;
    return (n == ADDR_WRAP) ? 30'd0 : n;
  endfunction

  assign wr_room = ({22'd0, bus.ib_count} >= 32'(BURST_LEN));
  assign rd_room = ({22'd0, bus.ob_count} <= 32'(OB_DEPTH - BURST_LEN));

  assign bus.p0_cmd_bl  = 6'(BURST_LEN - 1);
  assign bus.p0_wr_mask = 4'd0;

  // Strobes react to full/empty in the same cycle so stalls never over-issue.
  always_comb begin
    bus.ib_re            = (state == WR_FILL) && (req_cnt < BL) && !bus.p0_wr_full;
    bus.p0_cmd_en        = ((state == WR_CMD) || (state == RD_CMD)) && !bus.p0_cmd_full;
    bus.p0_rd_en         = (state == RD_DRAIN) && !bus.p0_rd_empty;
    bus.p0_cmd_instr     = (state == RD_CMD) ? 3'b001 : 3'b000;
    bus.p0_cmd_byte_addr = (state == RD_CMD) ? rd_addr : wr_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      req_cnt        <= '0;
      push_cnt       <= '0;
      pop_cnt        <= '0;
      wr_addr        <= '0;
      rd_addr        <= '0;
      bus.p0_wr_en   <= 1'b0;
      bus.p0_wr_data <= '0;
      bus.ob_we      <= 1'b0;
      bus.ob_data    <= '0;
    end else begin
      // Data paths are one-cycle registered copies of the FIFO outputs.
      bus.p0_wr_en <= (state == WR_FILL) && bus.ib_valid;
      if ((state == WR_FILL) && bus.ib_valid) bus.p0_wr_data <= bus.ib_data;
      bus.ob_we <= bus.p0_rd_en;
      if (bus.p0_rd_en) bus.ob_data <= bus.p0_rd_data;

      case (state)
        IDLE: begin
          req_cnt  <= '0;
          push_cnt <= '0;
          pop_cnt  <= '0;
          if (calib_done) begin
            if (writes_en && wr_room)      state <= WR_FILL;
            else if (reads_en && rd_room)  state <= RD_CMD;
          end
        end
        WR_FILL: begin
          if (bus.ib_re) req_cnt <= req_cnt + 7'd1;
          if (bus.ib_valid) begin
            push_cnt <= push_cnt + 7'd1;
            if (push_cnt == BL_M1) state <= WR_CMD;
          end
        end
        WR_CMD: begin
          if (!bus.p0_cmd_full) begin
            wr_addr <= next_addr(wr_addr);
            state   <= IDLE;
          end
        end
        RD_CMD: begin
          if (!bus.p0_cmd_full) begin
            rd_addr <= next_addr(rd_addr);
            state   <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (bus.p0_rd_en) begin
            pop_cnt <= pop_cnt + 7'd1;
            if (pop_cnt == BL_M1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BURST_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_burst_count <= '0;
      rd_burst_count <= '0;
    end else if (bus.p0_cmd_en) begin
      if ((state == WR_CMD) && (wr_burst_count != 16'hFFFF)) wr_burst_count <= wr_burst_count + 16'd1;
      if ((state == RD_CMD) && (rd_burst_count != 16'hFFFF)) rd_burst_count <= rd_burst_count + 16'd1;
    end
  end
`else
  assign wr_burst_count = 16'd0;
  assign rd_burst_count = 16'd0;
`endif

endmodule

// File: tb/tb_ddr2_burst_ctrl.sv
// Bench for ddr2_burst_ctrl: IDLE-decision vector table plus FIFO/MCB models with scoreboards.
module tb_ddr2_burst_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        calib_done = 1'b0;
  logic        writes_en = 1'b0;
  logic        reads_en = 1'b0;
  logic [15:0] wr_burst_count;
  logic [15:0] rd_burst_count;

  ddr2_burst_ctrl_if bus();

  ddr2_burst_ctrl #(.BURST_LEN(32), .OB_DEPTH(1024), .ADDR_WRAP(30'h100)) dut (
    .clk            (clk),
    .reset          (reset),
    .calib_done     (calib_done),
    .writes_en      (writes_en),
    .reads_en       (reads_en),
    .bus            (bus),
    .wr_burst_count (wr_burst_count),
    .rd_burst_count (rd_burst_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] ib_q[$];
  logic [31:0] wr_exp[$];
  logic [31:0] rd_q[$];
  logic [31:0] ob_exp[$];

  logic        ovr = 1'b1;
  logic [9:0]  ovr_val = 10'd0;
  logic [9:0]  ib_cnt_m = 10'd0;
  logic        rd_model_en = 1'b0;
  logic        mon_en = 1'b0;
  logic        lat_en = 1'b0;
  logic        stall_chk = 1'b0;
  logic        hold_chk = 1'b0;
  logic [29:0] wr_addr_exp = 30'd0;
  logic [29:0] rd_addr_exp = 30'd0;
  int          n_wr_cmd = 0, n_rd_cmd = 0, n_push = 0, n_ob = 0;
  int          cyc = 0, last_re_cyc = 0, n_rd_model = 0;

  typedef struct {
    logic       calib;
    logic       wen;
    logic       ren;
    logic [9:0] ib;
    logic [9:0] ob;
    logic       exp_re;
    logic       exp_rd;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [29:0] adv(input logic [29:0] a);
    logic [29:0] n;
    n = a + 30'h80;
    return (n == 30'h100) ? 30'h0 : n;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    wr_addr_exp = 30'd0;
    rd_addr_exp = 30'd0;
    n_wr_cmd = 0;
    n_rd_cmd = 0;
    n_push = 0;
    n_ob = 0;
  endtask

  task automatic preload(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      ib_q.push_back(32'(base + i));
      wr_exp.push_back(32'(base + i));
    end
  endtask

  assign bus.ib_count = ovr ? ovr_val : ib_cnt_m;

  // Pipe-in FIFO: data and valid appear the cycle after ib_re.
  always @(posedge clk) begin
    bus.ib_valid <= 1'b0;
    if (bus.ib_re && ib_q.size() > 0) begin
      bus.ib_data  <= ib_q.pop_front();
      bus.ib_valid <= 1'b1;
    end
    ib_cnt_m <= 10'(ib_q.size());
  end

  // MCB read path: each read command returns 32 tagged words.
  always @(posedge clk) begin
    if (bus.p0_rd_en && rd_q.size() > 0) void'(rd_q.pop_front());
    if (rd_model_en && bus.p0_cmd_en && bus.p0_cmd_instr == 3'b001) begin
      for (int i = 0; i < 32; i++) begin
        rd_q.push_back(32'hA0 + 32'(i) + 32'(n_rd_model) * 32'h100);
        ob_exp.push_back(32'hA0 + 32'(i) + 32'(n_rd_model) * 32'h100);
      end
      n_rd_model++;
    end
    bus.p0_rd_empty <= (rd_q.size() == 0);
    bus.p0_rd_data  <= (rd_q.size() > 0) ? rd_q[0] : 32'h0;
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.ib_re) last_re_cyc = cyc;
    if (stall_chk) chk("ib_re_during_wr_full", 32'(bus.ib_re), 32'd0);
    if (hold_chk)  chk("cmd_en_during_cmd_full", 32'(bus.p0_cmd_en), 32'd0);
    if (mon_en) begin
      if (bus.p0_wr_en) begin
        n_push++;
        if (wr_exp.size() == 0) chk("wr_extra_word", 32'd1, 32'd0);
        else chk("wr_data", bus.p0_wr_data, wr_exp.pop_front());
        chk("wr_mask", 32'(bus.p0_wr_mask), 32'd0);
      end
      if (bus.p0_cmd_en) begin
        chk("cmd_bl", 32'(bus.p0_cmd_bl), 32'd31);
        if (bus.p0_cmd_instr == 3'b000) begin
          chk("wr_cmd_addr", 32'(bus.p0_cmd_byte_addr), 32'(wr_addr_exp));
          if (lat_en) chk("last_re_to_cmd", 32'(cyc - last_re_cyc), 32'd2);
          wr_addr_exp = adv(wr_addr_exp);
          n_wr_cmd++;
        end else begin
          chk("rd_cmd_instr", 32'(bus.p0_cmd_instr), 32'd1);
          chk("rd_cmd_addr", 32'(bus.p0_cmd_byte_addr), 32'(rd_addr_exp));
          rd_addr_exp = adv(rd_addr_exp);
          n_rd_cmd++;
        end
      end
      if (bus.ob_we) begin
        n_ob++;
        if (ob_exp.size() == 0) chk("ob_extra_word", 32'd1, 32'd0);
        else chk("ob_data", bus.ob_data, ob_exp.pop_front());
      end
    end
  end

  initial begin
    int t;
    int snap;
    logic [31:0] exp_wr_cnt;
    logic [31:0] exp_rd_cnt;

    vt[0] = '{1'b0, 1'b1, 1'b1, 10'd40,   10'd0,   1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 1'b0, 10'd32,   10'd0,   1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 10'd31,   10'd0,   1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 10'd32,   10'd0,   1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 10'd31,   10'd0,   1'b0, 1'b1};
    vt[5] = '{1'b1, 1'b0, 1'b1, 10'd0,    10'd992, 1'b0, 1'b1};
    vt[6] = '{1'b1, 1'b0, 1'b1, 10'd0,    10'd993, 1'b0, 1'b0};
    vt[7] = '{1'b1, 1'b0, 1'b0, 10'd100,  10'd0,   1'b0, 1'b0};
    vt[8] = '{1'b1, 1'b1, 1'b0, 10'd1023, 10'd0,   1'b1, 1'b0};

    bus.ob_count    = 10'd0;
    bus.p0_cmd_full = 1'b0;
    bus.p0_wr_full  = 1'b0;

    do_reset();
    @(negedge clk);
    chk("rst_ib_re", 32'(bus.ib_re), 32'd0);
    chk("rst_cmd_en", 32'(bus.p0_cmd_en), 32'd0);
    chk("rst_wr_en", 32'(bus.p0_wr_en), 32'd0);
    chk("rst_ob_we", 32'(bus.ob_we), 32'd0);
    chk("rst_rd_en", 32'(bus.p0_rd_en), 32'd0);
    chk("rst_cmd_addr", 32'(bus.p0_cmd_byte_addr), 32'd0);
    chk("rst_cmd_bl", 32'(bus.p0_cmd_bl), 32'd31);
    chk("rst_wr_cnt", 32'(wr_burst_count), 32'd0);

    // IDLE decision table: one cycle from IDLE to ib_re or read command.
    for (int i = 0; i < 9; i++) begin
      tick(1);
      reset = 1'b1;
      ovr_val = vt[i].ib;
      bus.ob_count = vt[i].ob;
      calib_done = vt[i].calib;
      writes_en = vt[i].wen;
      reads_en = vt[i].ren;
      tick(1);
      reset = 1'b0;
      tick(1);
      @(negedge clk);
      chk($sformatf("vec%0d_ib_re", i), 32'(bus.ib_re), 32'(vt[i].exp_re));
      chk($sformatf("vec%0d_rd_cmd", i),
          32'(bus.p0_cmd_en && bus.p0_cmd_instr == 3'b001), 32'(vt[i].exp_rd));
    end

    tick(1);
    writes_en = 1'b0;
    reads_en = 1'b0;
    bus.ob_count = 10'd0;
    ovr = 1'b0;
    do_reset();
    tick(2);
    mon_en = 1'b1;
    rd_model_en = 1'b1;
    calib_done = 1'b1;

    // Two back-to-back write bursts of words 0..63.
    preload(0, 64);
    tick(2);
    lat_en = 1'b1;
    writes_en = 1'b1;
    t = 0;
    while (n_wr_cmd < 2 && t < 300) begin tick(1); t++; end
    chk("wr_cmds_phase1", 32'(n_wr_cmd), 32'd2);
    chk("wr_pushes_phase1", 32'(n_push), 32'd64);
    chk("wr_exp_empty1", 32'(wr_exp.size()), 32'd0);
    lat_en = 1'b0;

    // Third burst with a wr_full stall and a cmd_full hold; its address wraps to 0.
    preload(64, 32);
    t = 0;
    while (n_push < 74 && t < 200) begin tick(1); t++; end
    chk("wait_mid_fill", 32'(n_push >= 74), 32'd1);
    bus.p0_wr_full = 1'b1;
    stall_chk = 1'b1;
    tick(5);
    stall_chk = 1'b0;
    bus.p0_wr_full = 1'b0;
    bus.p0_cmd_full = 1'b1;
    t = 0;
    while (n_push < 96 && t < 200) begin tick(1); t++; end
    chk("wr_pushes_phase2", 32'(n_push), 32'd96);
    hold_chk = 1'b1;
    tick(3);
    hold_chk = 1'b0;
    chk("no_cmd_while_full", 32'(n_wr_cmd), 32'd2);
    bus.p0_cmd_full = 1'b0;
    t = 0;
    while (n_wr_cmd < 3 && t < 20) begin tick(1); t++; end
    chk("wr_cmd_after_full", 32'(n_wr_cmd), 32'd3);
    chk("wr_exp_empty2", 32'(wr_exp.size()), 32'd0);

    // Reads until three commands, then ob_count=993 blocks further reads.
    writes_en = 1'b0;
    reads_en = 1'b1;
    t = 0;
    while (n_rd_cmd < 3 && t < 400) begin tick(1); t++; end
    bus.ob_count = 10'd993;
    chk("rd_cmds_reached", 32'(n_rd_cmd), 32'd3);
    tick(150);
    chk("rd_cmds_blocked", 32'(n_rd_cmd), 32'd3);
    chk("ob_words", 32'(n_ob), 32'd96);
    chk("ob_exp_empty", 32'(ob_exp.size()), 32'd0);

`ifdef BURST_CTRL_STATS_EN
    exp_wr_cnt = 32'd3;
    exp_rd_cnt = 32'd3;
`else
    exp_wr_cnt = 32'd0;
    exp_rd_cnt = 32'd0;
`endif
    chk("wr_burst_count", 32'(wr_burst_count), exp_wr_cnt);
    chk("rd_burst_count", 32'(rd_burst_count), exp_rd_cnt);

    // Write has priority when both modes are set and a burst is available.
    reads_en = 1'b0;
    bus.ob_count = 10'd0;
    do_reset();
    preload(100, 32);
    tick(3);
    writes_en = 1'b1;
    reads_en = 1'b1;
    t = 0;
    while ((n_wr_cmd + n_rd_cmd) < 1 && t < 100) begin tick(1); t++; end
    reads_en = 1'b0;
    chk("prio_wr_first", 32'(n_wr_cmd), 32'd1);
    chk("prio_no_rd", 32'(n_rd_cmd), 32'd0);
    chk("prio_wr_exp_empty", 32'(wr_exp.size()), 32'd0);

    // Reset in the middle of WR_FILL aborts the burst without a command.
    preload(200, 32);
    t = 0;
    while (n_push < 37 && t < 100) begin tick(1); t++; end
    chk("abort_mid_fill", 32'(n_push >= 37), 32'd1);
    reset = 1'b1;
    tick(1);
    @(negedge clk);
    chk("abort_ib_re", 32'(bus.ib_re), 32'd0);
    chk("abort_wr_en", 32'(bus.p0_wr_en), 32'd0);
    chk("abort_wr_data", bus.p0_wr_data, 32'd0);
    chk("abort_cmd_en", 32'(bus.p0_cmd_en), 32'd0);
    chk("abort_cmd_addr", 32'(bus.p0_cmd_byte_addr), 32'd0);
    chk("abort_ob_we", 32'(bus.ob_we), 32'd0);
    chk("abort_ob_data", bus.ob_data, 32'd0);
    chk("abort_rd_en", 32'(bus.p0_rd_en), 32'd0);
    chk("abort_wr_cnt", 32'(wr_burst_count), 32'd0);
    tick(1);
    reset = 1'b0;
    wr_exp.delete();
    snap = n_wr_cmd;
    tick(80);
    chk("abort_no_cmd", 32'(n_wr_cmd - snap), 32'd0);
    chk("abort_no_push", 32'(wr_exp.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
